// File: rtl/sprite_plot_sink_pkg.sv
// Shared constants, state encoding and address helper for the sprite plot sink.
package sprite_plot_sink_pkg;

  localparam int SCR_W_DEF      = 160;
  localparam int SCR_H_DEF      = 120;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int COLOR_W_DEF    = 9;
  localparam int FB_ADDR_W      = 15;
  localparam int X_W            = 8;
  localparam int Y_W            = 7;

  // 3R3G3B magenta reserved by the sprite drawer as "no pixel".
  localparam logic [COLOR_W_DEF-1:0] TRANSPARENT = 9'b111000111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  // Linear framebuffer address Y*scr_w + X; fits FB_ADDR_W for on-screen pixels.
  function automatic logic [FB_ADDR_W-1:0] lin_addr(input logic [X_W-1:0] x,
                                                    input logic [Y_W-1:0] y,
                                                    input int scr_w);
    return FB_ADDR_W'(32'(y) * 32'(scr_w) + 32'(x));
  endfunction

endpackage

// File: rtl/sprite_plot_sink_fifo.sv
// Synchronous FIFO holding pending plot requests {X, Y, Color}.
module plot_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // A full FIFO may still accept a push when it pops in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; extra MSB distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write, no reset needed on the data array.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sprite_plot_sink.sv
// Receives sprite plot requests, writes them to the framebuffer and runs the
// clear-screen engine.
//
// Handshake: a plot is transferred in every cycle where Plot and Ready are both
// high at the rising edge; Ready never depends on Plot. Plot while Ready is low
// is dropped and counted, never held off.
module sprite_plot_sink
  import sprite_plot_sink_pkg::*;
#(
  parameter int SCR_W      = SCR_W_DEF,
  parameter int SCR_H      = SCR_H_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int COLOR_W    = COLOR_W_DEF
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [X_W-1:0]       X,
  input  logic [Y_W-1:0]       Y,
  input  logic [COLOR_W-1:0]   Color,
  input  logic                 Plot,
  output logic                 Ready,
  input  logic                 ClearReq,
  input  logic [COLOR_W-1:0]   ClearColor,
  output logic                 ClearDone,
  output logic [FB_ADDR_W-1:0] FbAddr,
  output logic [COLOR_W-1:0]   FbData,
  output logic                 FbWe,
  output logic [7:0]           DropCount,
  output logic [1:0]           DbgState
);
  localparam int ENT_W = X_W + Y_W + COLOR_W;
  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(SCR_W * SCR_H - 1);

  state_e                 state, state_next;
  logic                   fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [ENT_W-1:0]       in_ent, fifo_dout, src_ent;
  logic                   accept, in_range, push_req, draining, src_valid, clearing;
  logic                   drop_inc;
  logic [FB_ADDR_W-1:0]   clr_addr, addr_q;
  logic [COLOR_W-1:0]     clr_color, data_q;
  logic                   we_q;

  assign Ready    = (state == ST_IDLE) & ~fifo_full & ~Reset;
  assign accept   = Plot & Ready;
  assign in_range = (32'(X) < SCR_W) && (32'(Y) < SCR_H);
  assign push_req = accept & in_range;
  assign drop_inc = (Plot & ~Ready) | (accept & ~in_range);
  assign in_ent   = {X, Y, Color};

  // A request arriving at an empty FIFO bypasses it so the write lands the next
  // cycle; otherwise the oldest queued entry is issued first to keep order.
  assign draining  = (state == ST_IDLE) | (state == ST_DRAIN);
  assign fifo_pop  = draining & ~fifo_empty;
  assign fifo_push = push_req & ~fifo_empty;
  assign src_valid = draining & (~fifo_empty | push_req);
  assign src_ent   = fifo_empty ? in_ent : fifo_dout;

  plot_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (Clock),
    .rst   (Reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (in_ent),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state: drain queued plots before starting the fill.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (ClearReq) state_next = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_next = ST_CLEAR;
      ST_CLEAR: if (clr_addr == LAST_ADDR) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Clear colour capture and fill address counter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      clr_addr  <= '0;
      clr_color <= '0;
    end else begin
      if (state == ST_IDLE && ClearReq) clr_color <= ClearColor;
      if (state == ST_CLEAR) clr_addr <= clr_addr + FB_ADDR_W'(1);
      else                   clr_addr <= '0;
    end
  end

  // Registered plot write port.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (src_valid) begin
      we_q   <= 1'b1;
      addr_q <= lin_addr(src_ent[ENT_W-1 -: X_W], src_ent[COLOR_W+Y_W-1 -: Y_W], SCR_W);
      data_q <= src_ent[COLOR_W-1:0];
    end else begin
      we_q   <= 1'b0;
    end
  end

  // Saturating count of discarded plots.
  always_ff @(posedge Clock) begin
    if (Reset)                             DropCount <= '0;
    else if (drop_inc && DropCount != 8'hFF) DropCount <= DropCount + 8'd1;
  end

  // Plot writes and fill writes never overlap: no plot is issued while clearing.
  assign clearing  = (state == ST_CLEAR);
  assign FbWe      = we_q | clearing;
  assign FbAddr    = clearing ? clr_addr  : addr_q;
  assign FbData    = clearing ? clr_color : data_q;
  assign ClearDone = clearing & (clr_addr == LAST_ADDR);
  assign DbgState  = state;

endmodule

// File: tb/tb_sprite_plot_sink.sv
// Randomized bench for sprite_plot_sink with a cycle-timed write scoreboard.
module tb_sprite_plot_sink;
  import sprite_plot_sink_pkg::*;

  localparam int W    = 160;
  localparam int H    = 120;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  x = '0;
  logic [6:0]  y = '0;
  logic [8:0]  color = '0;
  logic        plot = 1'b0;
  logic        clear_req = 1'b0;
  logic [8:0]  clear_color = '0;
  logic        ready, clear_done, fb_we;
  logic [14:0] fb_addr;
  logic [8:0]  fb_data;
  logic [7:0]  drop_count;
  logic [1:0]  dbg_state;

  // Expected writes: {cycle[56:25], addr[24:10], data[9:1], clear_done[0]}
  logic [56:0] exp_q[$];
  int cyc = 0;
  int clear_end = -1;
  int clear_start = -1;
  int exp_drop = 0;
  bit rst_q = 1'b0;
  int n_cmp = 0;
  int n_fail = 0;

  sprite_plot_sink dut (
    .Clock      (clk),
    .Reset      (rst),
    .X          (x),
    .Y          (y),
    .Color      (color),
    .Plot       (plot),
    .Ready      (ready),
    .ClearReq   (clear_req),
    .ClearColor (clear_color),
    .ClearDone  (clear_done),
    .FbAddr     (fb_addr),
    .FbData     (fb_data),
    .FbWe       (fb_we),
    .DropCount  (drop_count),
    .DbgState   (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a plot sampled at edge e while idle lands in cycle e; a
  // clear sampled at edge e keeps the sink busy for cycles e..e+NPIX and
  // writes pixel k in cycle e+1+k.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      exp_drop  = 0;
      clear_end = -1;
      rst_q     = 1'b1;
    end else begin
      rst_q = 1'b0;
      if (plot) begin
        if (clear_end < cyc && x < W && y < H)
          exp_q.push_back({32'(cyc + 1), 15'(y * W + x), color, 1'b0});
        else if (exp_drop < 255)
          exp_drop++;
      end
      if (clear_req && clear_end < cyc) begin
        for (int k = 0; k < NPIX; k++)
          exp_q.push_back({32'(cyc + 2 + k), 15'(k), clear_color, k == NPIX - 1});
        clear_start = cyc + 1;
        clear_end   = cyc + 1 + NPIX;
      end
    end
    cyc++;
  end

  // Monitor: compares outputs mid-cycle against the model.
  initial forever begin
    logic [56:0] head;
    logic        exp_we;
    @(negedge clk);
    if (cyc >= 1) begin
      check("ready", 64'(ready), 64'((clear_end < cyc) && !rst));
      check("drop_count", 64'(drop_count), 64'(exp_drop));
      if (rst_q) begin
        check("rst_addr", 64'(fb_addr), 64'(0));
        check("rst_data", 64'(fb_data), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
      end
      while (exp_q.size() > 0 && int'(exp_q[0][56:25]) < cyc) begin
        head = exp_q.pop_front();
        check("missed_write", 64'(head[24:0]), 64'h1_0000_0000);
      end
      exp_we = 1'b0;
      if (exp_q.size() > 0) begin
        head = exp_q[0];
        exp_we = (int'(head[56:25]) == cyc);
      end
      check("fb_we", 64'(fb_we), 64'(exp_we));
      if (exp_we) begin
        head = exp_q.pop_front();
        if (fb_we) check("fb_write", 64'({fb_addr, fb_data, clear_done}), 64'(head[24:0]));
      end
      if (!fb_we) check("done_without_we", 64'(clear_done), 64'(0));
    end
  end

  // Driver tasks: inputs change 2 time units after the rising edge.
  task automatic drive_plot(input logic [7:0] px, input logic [6:0] py, input logic [8:0] pc);
    @(posedge clk); #2;
    plot = 1'b1; x = px; y = py; color = pc; clear_req = 1'b0;
  endtask

  task automatic drive_idle(input int n);
    repeat (n) begin
      @(posedge clk); #2;
      plot = 1'b0; clear_req = 1'b0;
    end
  endtask

  task automatic drive_clear(input logic [8:0] cc, input logic with_plot);
    @(posedge clk); #2;
    clear_req = 1'b1; clear_color = cc; plot = with_plot;
    x = 8'($urandom_range(0, W - 1)); y = 7'($urandom_range(0, H - 1)); color = 9'($urandom);
  endtask

  task automatic random_plot();
    drive_plot(8'($urandom_range(0, 175)), 7'($urandom_range(0, 127)), 9'($urandom));
  endtask

  task automatic wait_idle();
    int budget = 25000;
    while (cyc <= clear_end && budget > 0) begin
      drive_idle(1);
      budget--;
    end
    n_cmp++;
    if (budget == 0) begin
      n_fail++;
      $display("FAIL clear_timeout: sink still busy at cycle %0d, expected idle by %0d", cyc, clear_end + 1);
    end
  endtask

  // Stimulus
  initial begin
    int budget;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Single plot, address 2*160+3
    drive_plot(8'd3, 7'd2, 9'h1FF);
    drive_idle(3);

    // Back-to-back plots
    for (int i = 0; i < 6; i++)
      drive_plot(8'($urandom_range(0, W - 1)), 7'($urandom_range(0, H - 1)), 9'($urandom));
    drive_idle(2);

    // Out-of-range and corner coordinates
    drive_plot(8'd160, 7'd0, 9'h0AA);
    drive_plot(8'd0, 7'd120, 9'h155);
    drive_plot(8'd159, 7'd119, 9'h1C7);
    drive_plot(8'd0, 7'd0, 9'h001);
    drive_plot(8'd255, 7'd127, 9'h0F0);
    drive_idle(2);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) random_plot();
      else drive_idle(1);
    end

    // Three plots, then a black clear with a plot in the same cycle
    for (int i = 0; i < 3; i++)
      drive_plot(8'($urandom_range(0, W - 1)), 7'($urandom_range(0, H - 1)), 9'($urandom));
    drive_clear(9'h000, 1'b1);
    drive_idle(1);
    // Plots and repeated clear requests while busy are dropped/ignored
    for (int i = 0; i < 20; i++) random_plot();
    drive_clear(9'h1FF, 1'b0);
    // Plot held long enough to saturate the drop counter
    for (int i = 0; i < 300; i++) random_plot();
    drive_idle(1);
    wait_idle();
    for (int i = 0; i < 40; i++) random_plot();
    drive_idle(2);

    // Clear aborted by reset at pixel 500
    drive_clear(9'($urandom), 1'b0);
    drive_idle(1);
    budget = 2000;
    while (cyc < clear_start + 501 && budget > 0) begin
      drive_idle(1);
      budget--;
    end
    n_cmp++;
    if (budget == 0) begin
      n_fail++;
      $display("FAIL abort_wait: cycle %0d, expected to reach %0d", cyc, clear_start + 501);
    end
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    for (int i = 0; i < 30; i++) random_plot();
    drive_idle(5);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_writes: got %0d pending expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
